// File: rtl/ctu_fanout_dispatcher.sv
// Drains the source CTU, looks up each popped gate's fanout list in the FT and
// writes every fanout entry into the destination CTU (which removes duplicates).
module ctu_fanout_dispatcher #(
  parameter int data_wd    = 11,
  parameter int hi         = 10,
  parameter int lo         = 0,
  parameter int ft_add_wd  = 12,
  parameter int cnt_wd     = 8,
  parameter int ft_data_wd = 20,
  parameter int stat_wd    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic                  src_empty,
  input  logic [data_wd-1:0]    src_EV_out,
  output logic                  src_cs,
  output logic                  src_rd,
  output logic                  ft_rd,
  output logic [ft_add_wd-1:0]  ft_add,
  input  logic [ft_data_wd-1:0] ft_data,
  input  logic                  dst_full,
  output logic                  dst_cs,
  output logic                  dst_wr,
  output logic [data_wd-1:0]    dst_EV_in,
  output logic [stat_wd-1:0]    gate_cnt,
  output logic [stat_wd-1:0]    ev_cnt
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    HDR   = 3'd2,
    FETCH = 3'd3,
    EMIT  = 3'd4,
    STALL = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam logic [cnt_wd-1:0]    rem_one_c  = cnt_wd'(1'b1);
  localparam logic [cnt_wd-1:0]    cnt_zero_c = cnt_wd'(1'b0);
  localparam logic [ft_add_wd-1:0] ptr_one_c  = ft_add_wd'(1'b1);
  localparam logic [stat_wd-1:0]   stat_one_c = stat_wd'(1'b1);

  state_t                 state_r;
  logic [ft_add_wd-1:0]   ptr_r;
  logic [cnt_wd-1:0]      rem_r;
  logic [data_wd-1:0]     hold_r;
  logic [stat_wd-1:0]     gate_cnt_r;
  logic [stat_wd-1:0]     ev_cnt_r;

  logic [cnt_wd-1:0]      hdr_cnt_s;
  logic [ft_add_wd-1:0]   hdr_base_s;
  logic [ft_add_wd-1:0]   hdr_idx_s;
  logic [data_wd-1:0]     fan_ev_s;

  logic                   src_rd_s;
  logic                   ft_rd_s;
  logic [ft_add_wd-1:0]   ft_add_s;
  logic                   dst_wr_s;
  logic [data_wd-1:0]     dst_ev_s;
  logic                   busy_s;
  logic                   done_s;

  assign hdr_cnt_s  = ft_data[cnt_wd+ft_add_wd-1:ft_add_wd];
  assign hdr_base_s = ft_data[ft_add_wd-1:0];
  assign hdr_idx_s  = ft_add_wd'(src_EV_out[hi:lo]);
  assign fan_ev_s   = ft_data[data_wd-1:0];

  // State, fanout pointer/remaining count, stall hold and pass statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      ptr_r      <= {ft_add_wd{1'b0}};
      rem_r      <= {cnt_wd{1'b0}};
      hold_r     <= {data_wd{1'b0}};
      gate_cnt_r <= {stat_wd{1'b0}};
      ev_cnt_r   <= {stat_wd{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_r    <= CHECK;
            gate_cnt_r <= {stat_wd{1'b0}};
            ev_cnt_r   <= {stat_wd{1'b0}};
          end
        end
        CHECK: begin
          if (src_empty) begin
            state_r <= DONE;
          end else begin
            gate_cnt_r <= gate_cnt_r + stat_one_c;
            state_r    <= HDR;
          end
        end
        HDR: begin
          rem_r   <= hdr_cnt_s;
          ptr_r   <= hdr_base_s;
          state_r <= (hdr_cnt_s == cnt_zero_c) ? CHECK : FETCH;
        end
        FETCH: begin
          ptr_r   <= ptr_r + ptr_one_c;
          state_r <= EMIT;
        end
        EMIT: begin
          hold_r <= fan_ev_s;
          if (!dst_full) begin
            ev_cnt_r <= ev_cnt_r + stat_one_c;
            rem_r    <= rem_r - rem_one_c;
            state_r  <= (rem_r == rem_one_c) ? CHECK : FETCH;
          end else begin
            state_r <= STALL;
          end
        end
        STALL: begin
          if (!dst_full) begin
            ev_cnt_r <= ev_cnt_r + stat_one_c;
            rem_r    <= rem_r - rem_one_c;
            state_r  <= (rem_r == rem_one_c) ? CHECK : FETCH;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Strobes decoded from state; the EMIT write uses live FT data, STALL replays the held entry
  always_comb begin
    src_rd_s = 1'b0;
    ft_rd_s  = 1'b0;
    ft_add_s = {ft_add_wd{1'b0}};
    dst_wr_s = 1'b0;
    dst_ev_s = hold_r;
    busy_s   = 1'b0;
    done_s   = 1'b0;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
      end
      CHECK: begin
        busy_s = 1'b1;
        if (!src_empty) begin
          src_rd_s = 1'b1;
          ft_rd_s  = 1'b1;
          ft_add_s = hdr_idx_s;
        end else begin
          src_rd_s = 1'b0;
        end
      end
      HDR: begin
        busy_s = 1'b1;
      end
      FETCH: begin
        busy_s   = 1'b1;
        ft_rd_s  = 1'b1;
        ft_add_s = ptr_r;
      end
      EMIT: begin
        busy_s   = 1'b1;
        dst_ev_s = fan_ev_s;
        if (!dst_full) begin
          dst_wr_s = 1'b1;
        end else begin
          dst_wr_s = 1'b0;
        end
      end
      STALL: begin
        busy_s = 1'b1;
        if (!dst_full) begin
          dst_wr_s = 1'b1;
        end else begin
          dst_wr_s = 1'b0;
        end
      end
      DONE: begin
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  assign src_rd    = src_rd_s;
  assign src_cs    = src_rd_s;
  assign ft_rd     = ft_rd_s;
  assign ft_add    = ft_add_s;
  assign dst_wr    = dst_wr_s;
  assign dst_cs    = dst_wr_s;
  assign dst_EV_in = dst_ev_s;
  assign busy      = busy_s;
  assign done      = done_s;
  assign gate_cnt  = gate_cnt_r;
  assign ev_cnt    = ev_cnt_r;

endmodule

// File: tb/tb_ctu_fanout_dispatcher.sv
// Bench for ctu_fanout_dispatcher: behavioural source CTU and FT models, a
// per-pass reference model feeding scoreboard queues, and a negedge monitor.
module tb_ctu_fanout_dispatcher;
  localparam int DW = 11;
  localparam int AW = 12;
  localparam int CW = 8;
  localparam int FW = 20;
  localparam int SW = 16;

  logic clk = 1'b0;
  logic rst, start, busy, done;
  logic src_empty, src_cs, src_rd, ft_rd, dst_full, dst_cs, dst_wr;
  logic [DW-1:0] src_EV_out, dst_EV_in;
  logic [AW-1:0] ft_add;
  logic [FW-1:0] ft_data;
  logic [SW-1:0] gate_cnt, ev_cnt;

  always #5 clk = ~clk;

  ctu_fanout_dispatcher dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .src_empty(src_empty), .src_EV_out(src_EV_out), .src_cs(src_cs), .src_rd(src_rd),
    .ft_rd(ft_rd), .ft_add(ft_add), .ft_data(ft_data),
    .dst_full(dst_full), .dst_cs(dst_cs), .dst_wr(dst_wr), .dst_EV_in(dst_EV_in),
    .gate_cnt(gate_cnt), .ev_cnt(ev_cnt)
  );

  // source CTU model: array with read index, FT model: synchronous memory
  logic [FW-1:0] ft_mem [0:4095];
  logic [DW-1:0] src_mem [0:255];
  int src_len = 0;
  int src_idx = 0;
  assign src_empty  = (src_idx == src_len);
  assign src_EV_out = src_mem[src_idx[7:0]];

  always @(posedge clk) begin
    if (src_rd) src_idx <= src_idx + 1;
    if (ft_rd) ft_data <= ft_mem[ft_add];
  end

  logic rand_full = 1'b0;
  logic force_full = 1'b0;
  int full_mode = 0;
  assign dst_full = (full_mode != 0) ? rand_full : force_full;

  always @(posedge clk) begin
    #1;
    rand_full = ($urandom_range(0, 2) == 0);
  end

  logic [AW-1:0] exp_ft[$];
  logic [DW-1:0] exp_dst[$];
  int n_chk = 0;
  int n_fail = 0;
  int exp_gate, exp_ev, exp_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT strobes, plus handshake rules
  always @(negedge clk) begin
    if (!rst) begin
      if (src_rd || src_cs) begin
        check("src_cs_eq_rd", src_cs, src_rd);
        check("src_rd_when_empty", src_empty, 1'b0);
      end
      if (dst_wr || dst_cs) begin
        check("dst_cs_eq_wr", dst_cs, dst_wr);
        check("dst_wr_while_full", dst_full, 1'b0);
        check("src_rd_with_dst_wr", src_rd, 1'b0);
        if (exp_dst.size() == 0) check("dst_extra_write", 1'b1, 1'b0);
        else check("dst_EV_in", dst_EV_in, exp_dst.pop_front());
      end
      if (ft_rd) begin
        if (exp_ft.size() == 0) check("ft_extra_read", 1'b1, 1'b0);
        else check("ft_add", ft_add, exp_ft.pop_front());
      end
    end
  end

  task automatic push_src(input logic [DW-1:0] e);
    src_mem[src_len] = e;
    src_len++;
  endtask

  // reference: walk pending source entries through the FT tables
  task automatic model_pass();
    logic [AW-1:0] h_addr, base, a;
    logic [FW-1:0] hdr;
    int cnt;
    exp_gate = 0;
    exp_ev = 0;
    exp_cyc = 2;
    for (int i = src_idx; i < src_len; i++) begin
      h_addr = AW'(src_mem[i]);
      hdr = ft_mem[h_addr];
      cnt = int'(hdr[CW+AW-1:AW]);
      base = hdr[AW-1:0];
      exp_ft.push_back(h_addr);
      exp_gate++;
      exp_ev += cnt;
      exp_cyc += 2 + 2 * cnt;
      for (int k = 0; k < cnt; k++) begin
        a = base + AW'(k);
        exp_ft.push_back(a);
        exp_dst.push_back(ft_mem[a][DW-1:0]);
      end
    end
  endtask

  task automatic run_pass(input string tag, input int stall_at, input logic [DW-1:0] stall_val);
    int c;
    bit got;
    model_pass();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    c = 1;
    got = 1'b0;
    while (c < 3000) begin
      if (stall_at != 0) force_full = (c >= stall_at) && (c < stall_at + 4);
      @(negedge clk);
      if (c == 1) check({tag, "_busy"}, busy, 1'b1);
      if (stall_at != 0 && force_full) check({tag, "_stall_hold"}, dst_EV_in, stall_val);
      if (done) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      c++;
    end
    force_full = 1'b0;
    if (!got) begin
      check({tag, "_done_timeout"}, 1'b0, 1'b1);
      exp_dst.delete();
      exp_ft.delete();
    end else begin
      if (full_mode == 0 && stall_at == 0) check({tag, "_done_latency"}, c, exp_cyc);
      check({tag, "_gate_cnt"}, gate_cnt, exp_gate);
      check({tag, "_ev_cnt"}, ev_cnt, exp_ev);
      check({tag, "_dst_left"}, exp_dst.size(), 0);
      check({tag, "_ft_left"}, exp_ft.size(), 0);
      check({tag, "_src_drained"}, src_idx, src_len);
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 1'b0);
      check({tag, "_busy_end"}, busy, 1'b0);
      check({tag, "_gate_hold"}, gate_cnt, exp_gate);
    end
  endtask

  initial begin
    int n;
    logic [DW-1:0] e;
    for (int i = 0; i < 4096; i++) ft_mem[i] = FW'($urandom);
    for (int i = 0; i < 256; i++) src_mem[i] = '0;
    ft_mem[5]      = 20'h03100;
    ft_mem[12'h100] = 20'd7;
    ft_mem[12'h101] = 20'd9;
    ft_mem[12'h102] = 20'd7;
    ft_mem[3]      = 20'h00000;
    ft_mem[4]      = 20'h01020;
    ft_mem[12'h020] = 20'd12;
    ft_mem[6]      = 20'h02FFF;
    ft_mem[12'hFFF] = 20'h0055A;
    ft_mem[12'h000] = 20'h003C3;

    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_dst_wr", dst_wr, 1'b0);
    check("rst_ft_rd", ft_rd, 1'b0);
    check("rst_gate_cnt", gate_cnt, 16'h0000);
    check("rst_ev_cnt", ev_cnt, 16'h0000);

    run_pass("empty", 0, 11'd0);
    push_src(11'd5);
    run_pass("fan3", 0, 11'd0);
    push_src(11'd3);
    push_src(11'd4);
    run_pass("cnt0", 0, 11'd0);
    push_src(11'd5);
    run_pass("stall", 4, 11'd7);
    push_src(11'd6);
    run_pass("wrap", 0, 11'd0);

    // reset while stalled
    push_src(11'd5);
    model_pass();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      force_full = (c >= 4);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    force_full = 1'b0;
    exp_dst.delete();
    exp_ft.delete();
    src_len = src_idx;
    @(negedge clk);
    check("midrst_busy", busy, 1'b0);
    check("midrst_dst_wr", dst_wr, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_gate_cnt", gate_cnt, 16'h0000);
    check("midrst_ev_cnt", ev_cnt, 16'h0000);
    push_src(11'd5);
    run_pass("after_rst", 0, 11'd0);

    for (int p = 0; p < 8; p++) begin
      n = $urandom_range(1, 5);
      for (int j = 0; j < n; j++) begin
        e = DW'($urandom_range(0, 2047));
        ft_mem[e] = {CW'($urandom_range(0, 4)), AW'($urandom)};
        push_src(e);
      end
      full_mode = p % 2;
      run_pass("rand", 0, 11'd0);
    end
    full_mode = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
